// File: rtl/kernel_result_writer_if.sv
// kernel_result_writer_if: result handshake, frame RAM write port and status of the writeback stage
interface kernel_result_writer_if #(
    parameter int AW = 12,
    parameter int IW = 20,
    parameter int DW = 13
);
    logic          start;
    logic          in_valid;
    logic [IW-1:0] in_data;
    logic          in_ready;
    logic [AW-1:0] pix_index;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          frame_done;
    logic [AW:0]   sat_count;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, pix_index, wr_en, wr_addr, wr_data, busy, frame_done, sat_count
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, pix_index, wr_en, wr_addr, wr_data, busy, frame_done, sat_count
    );
endinterface

// File: rtl/kernel_result_writer.sv
// kernel_result_writer: rescales, clamps and writes one NxN frame of filter results in raster order
module kernel_result_writer #(
    parameter int N     = 64,
    parameter int AW    = 12,
    parameter int IW    = 20,
    parameter int DW    = 13,
    parameter int SHIFT = 0,
    parameter int MAXV  = 255
) (
    input logic clk,
    input logic rst,
    kernel_result_writer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [AW-1:0]        LAST  = AW'(N * N - 1);
    localparam logic [AW:0]          FRAME = (AW + 1)'(N * N);
    localparam logic signed [IW:0]   MAXS  = (IW + 1)'(MAXV);
    localparam logic [DW-1:0]        MAXD  = DW'(MAXV);

    state_t            state_q;
    logic              in_ready_q, wr_en_q, busy_q, done_q;
    logic [AW-1:0]     pix_q, wr_addr_q;
    logic [DW-1:0]     wr_data_q;
    logic [AW:0]       sat_q;
    logic signed [IW:0] scaled_d;
    logic              clamp_d, accept_d;
    logic [DW-1:0]     val_d;

    // sign-extend one bit so the shift and both clamp compares stay exact
    always_comb begin
        scaled_d = $signed({bus.in_data[IW-1], bus.in_data}) >>> SHIFT;
        clamp_d  = (scaled_d < 0) || (scaled_d > MAXS);
        val_d    = (scaled_d < 0) ? '0 : (scaled_d > MAXS) ? MAXD : scaled_d[DW-1:0];
        accept_d = bus.in_valid & in_ready_q;
    end

    // frame sequencer with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
            pix_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            sat_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (bus.start) begin
                        state_q    <= RUN;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        pix_q      <= '0;
                        sat_q      <= '0;
                    end
                end
                RUN: begin
                    wr_en_q <= accept_d;
                    if (accept_d) begin
                        wr_addr_q <= pix_q;
                        wr_data_q <= val_d;
                        if (clamp_d && sat_q != FRAME)
                            sat_q <= sat_q + 1'b1;
                        if (pix_q == LAST) begin
                            state_q    <= DONE;
                            pix_q      <= '0;
                            in_ready_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            pix_q <= pix_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.pix_index  = pix_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.sat_count  = sat_q;
endmodule

// File: tb/tb_kernel_result_writer.sv
// tb_kernel_result_writer: randomized frames on two writers (shift 0 and 4) against a frame-level model
module tb_kernel_result_writer;
    localparam int N = 4, AW = 12, IW = 20, DW = 13, MAXV = 255;
    localparam int FR = N * N;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    kernel_result_writer_if #(.AW(AW), .IW(IW), .DW(DW)) bus0 ();
    kernel_result_writer_if #(.AW(AW), .IW(IW), .DW(DW)) bus1 ();

    kernel_result_writer #(.N(N), .AW(AW), .IW(IW), .DW(DW), .SHIFT(0), .MAXV(MAXV))
        u_s0 (.clk(clk), .rst(rst), .bus(bus0));
    kernel_result_writer #(.N(N), .AW(AW), .IW(IW), .DW(DW), .SHIFT(4), .MAXV(MAXV))
        u_s4 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // frame-level model: mode 0 idle, 1 running, 2 finishing
    int mode = 0, idx = 0, eaddr = 0;
    int edata[2] = '{0, 0};
    int esat[2]  = '{0, 0};
    bit ewen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampv(input logic [IW-1:0] d, input int sh, output bit c);
        int s;
        s = int'($signed(d)) >>> sh;
        c = (s < 0) || (s > MAXV);
        return s < 0 ? 0 : (s > MAXV ? MAXV : s);
    endfunction

    task automatic chk_dut(input int k, input logic rdy, input logic bsy, input logic dn,
                           input logic wen, input logic [AW-1:0] pix, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [AW:0] sat);
        string p;
        p = (k == 0) ? "s0" : "s4";
        chk({p, ".in_ready"}, 32'(rdy), 32'(mode == 1));
        chk({p, ".busy"}, 32'(bsy), 32'(mode != 0));
        chk({p, ".frame_done"}, 32'(dn), 32'(mode == 2));
        chk({p, ".pix_index"}, 32'(pix), idx);
        chk({p, ".wr_en"}, 32'(wen), 32'(ewen));
        chk({p, ".wr_addr"}, 32'(addr), eaddr);
        chk({p, ".wr_data"}, 32'(data), edata[k]);
        chk({p, ".sat_count"}, 32'(sat), esat[k]);
    endtask

    task automatic check_all();
        chk_dut(0, bus0.in_ready, bus0.busy, bus0.frame_done, bus0.wr_en, bus0.pix_index,
                bus0.wr_addr, bus0.wr_data, bus0.sat_count);
        chk_dut(1, bus1.in_ready, bus1.busy, bus1.frame_done, bus1.wr_en, bus1.pix_index,
                bus1.wr_addr, bus1.wr_data, bus1.sat_count);
    endtask

    task automatic drive(input bit s, input bit v, input logic [IW-1:0] d);
        bus0.start = s; bus0.in_valid = v; bus0.in_data = d;
        bus1.start = s; bus1.in_valid = v; bus1.in_data = d;
    endtask

    task automatic step(input bit s, input bit v, input logic [IW-1:0] d);
        bit c;
        @(negedge clk);
        drive(s, v, d);
        @(posedge clk);
        ewen = 0;
        if (mode == 0) begin
            if (s) begin
                mode = 1; idx = 0; esat = '{0, 0};
            end
        end else if (mode == 1) begin
            if (v) begin
                ewen = 1;
                eaddr = idx;
                for (int k = 0; k < 2; k++) begin
                    edata[k] = clampv(d, k * 4, c);
                    if (c && esat[k] < FR) esat[k]++;
                end
                idx++;
                if (idx == FR) begin
                    idx = 0; mode = 2;
                end
            end
        end else begin
            mode = 0;
        end
        #1 check_all();
    endtask

    task automatic do_reset(input bit v);
        @(negedge clk);
        drive(1'b0, v, '0);
        #2 rst = 1'b1;
        #1;
        mode = 0; idx = 0; eaddr = 0; ewen = 0;
        edata = '{0, 0}; esat = '{0, 0};
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [IW-1:0] rnd_data();
        return ($urandom_range(0, 3) == 0) ? IW'($urandom) : IW'($urandom_range(0, 5000));
    endfunction

    initial begin
        int acc;
        bit v;
        drive(1'b0, 1'b0, '0);
        do_reset(1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, IW'(123));

        step(1'b1, 1'b0, '0);
        for (int i = 0; i < FR; i++) step(1'b0, 1'b1, IW'(i));
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);

        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, IW'(-32));
        step(1'b0, 1'b1, IW'(4095));
        step(1'b0, 1'b1, IW'(5000));
        step(1'b0, 1'b1, IW'(160));
        for (int i = 4; i < FR; i++) step(1'b0, 1'b1, IW'($urandom_range(0, 4095)));
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        chk("clamp_frame_sat", 32'(bus1.sat_count), 2);

        step(1'b1, 1'b0, '0);
        acc = 0;
        for (int i = 0; acc < FR; i++) begin
            v = (i % 3 == 0);
            step(1'b0, v, rnd_data());
            acc += int'(v);
        end
        step(1'b0, 1'b0, '0);

        step(1'b1, 1'b0, '0);
        acc = 0;
        while (acc < FR) begin
            v = $urandom_range(0, 1) == 1;
            step(acc == 7, v, rnd_data());
            acc += int'(v);
        end
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b0, '0);

        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, IW'(20'hFFFFF - i * 700));
        do_reset(1'b0);
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, rnd_data());
        chk("restart_addr", 32'(bus0.wr_addr), 0);

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0, rnd_data());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
